// File: rtl/song_pkg.sv
// Shared types and constants for the note-ROM music player's playback controller.
package song_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } song_state_e;

    localparam int NOTE_REST = 0;

    function automatic int beat_div(input int clk_hz, input int beat_hz);
        return clk_hz / beat_hz;
    endfunction

    // A divide-by-1 timer still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/song_if.sv
// Note-ROM and tone-generator bus between the sequencer (master) and the player datapath.
interface song_if #(
    parameter int ADDR_W = 10,
    parameter int NOTE_W = 5
);
    // rom_data must reflect rom_addr one clock after rom_addr changes; tone_code
    // is only meaningful while tone_en is high. There is no back-pressure.
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0] tone_code;
    logic              tone_en;

    modport master (
        output rom_addr,
        output tone_code,
        output tone_en,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  tone_code,
        input  tone_en,
        output rom_data
    );

endinterface

// File: rtl/beat_timer.sv
// Beat timebase: counts DIV clocks while running and emits a registered one-cycle tick.
module beat_timer
    import song_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic in_clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Holding (neither run nor clear) freezes the count so a pause resumes mid-beat.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                tick  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Playback controller: transport FSM, note-ROM address stepper and registered note output.
module song_sequencer
    import song_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BEAT_HZ   = 8,
    parameter int ADDR_W    = 10,
    parameter int LAST_ADDR = 420,
    parameter int NOTE_W    = 5
) (
    input  logic        in_clk,
    input  logic        rst,
    input  logic        play_btn,
    input  logic        pause_btn,
    input  logic        stop_btn,
    input  logic        loop_en,
    song_if.master      bus,
    output logic        beat_tick,
    output logic        done,
    output logic [1:0]  state
);

    localparam int                BEAT_DIV    = beat_div(CLK_HZ, BEAT_HZ);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(LAST_ADDR);
    localparam logic [NOTE_W-1:0] NOTE_SILENT = NOTE_W'(NOTE_REST);

    if (LAST_ADDR < 0 || LAST_ADDR >= (1 << ADDR_W)) begin : g_bad_last_addr
        $error("song_sequencer: LAST_ADDR does not fit in ADDR_W bits");
    end
    if (BEAT_DIV < 2) begin : g_bad_beat_div
        $error("song_sequencer: CLK_HZ/BEAT_HZ must be at least 2");
    end

    song_state_e       state_q;
    song_state_e       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [NOTE_W-1:0] note_q;
    logic              addr_moved_q;
    logic              done_q;

    logic at_last;
    logic step_beat;
    logic song_end;
    logic addr_clr;
    logic addr_step;
    logic timer_run;
    logic timer_clear;

    beat_timer #(
        .DIV (BEAT_DIV)
    ) u_beat_timer (
        .in_clk (in_clk),
        .rst    (rst),
        .run    (timer_run),
        .clear  (timer_clear),
        .tick   (beat_tick)
    );

    // Stop beats everything; reaching the end of a non-looping song beats a pause.
    always_comb begin
        state_d   = state_q;
        at_last   = (addr_q == ADDR_LAST);
        step_beat = (state_q == ST_PLAY) && beat_tick && !stop_btn;
        song_end  = step_beat && at_last && !loop_en;
        case (state_q)
            ST_IDLE: begin
                if (play_btn && !stop_btn) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (stop_btn)                     state_d = ST_IDLE;
                else if (song_end)                state_d = ST_DONE;
                else if (pause_btn && !play_btn)  state_d = ST_PAUSE;
            end
            ST_PAUSE, ST_DONE: begin
                if (stop_btn)      state_d = ST_IDLE;
                else if (play_btn) state_d = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_clr    = stop_btn || (step_beat && at_last);
        addr_step   = step_beat && !at_last;
        timer_run   = (state_q == ST_PLAY);
        timer_clear = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= song_end;
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            addr_moved_q <= 1'b0;
        end else begin
            addr_moved_q <= addr_clr || addr_step;
            if (addr_clr)       addr_q <= '0;
            else if (addr_step) addr_q <= addr_q + 1'b1;
        end
    end

    // The ROM output is stale for the cycle right after an address move, so skip that one.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            note_q <= '0;
        end else if (state_q == ST_PLAY && !addr_moved_q) begin
            note_q <= bus.rom_data;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.tone_code = note_q;
    assign bus.tone_en   = (state_q == ST_PLAY) && (note_q != NOTE_SILENT);
    assign done          = done_q;
    assign state         = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BEAT_DIV=10, LAST_ADDR=3 and ROM {0,5,7,9}.
module tb_song_sequencer;

    logic       in_clk = 1'b0;
    logic       rst;
    logic       play_btn;
    logic       pause_btn;
    logic       stop_btn;
    logic       loop_en;
    logic       beat_tick;
    logic       done;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    logic [4:0] rom_tab [4] = '{5'd0, 5'd5, 5'd7, 5'd9};

    song_if #(.ADDR_W(10), .NOTE_W(5)) bus ();

    song_sequencer #(
        .CLK_HZ    (80),
        .BEAT_HZ   (8),
        .ADDR_W    (10),
        .LAST_ADDR (3),
        .NOTE_W    (5)
    ) dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .play_btn  (play_btn),
        .pause_btn (pause_btn),
        .stop_btn  (stop_btn),
        .loop_en   (loop_en),
        .bus       (bus),
        .beat_tick (beat_tick),
        .done      (done),
        .state     (state)
    );

    always #5 in_clk = ~in_clk;

    // Synchronous note ROM with one clock of read latency.
    always @(posedge in_clk) bus.rom_data <= rom_tab[bus.rom_addr[1:0]];

    task automatic tick_n(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic pulse(input logic p, input logic pa, input logic s);
        play_btn  = p;
        pause_btn = pa;
        stop_btn  = s;
        tick_n(1);
        play_btn  = 1'b0;
        pause_btn = 1'b0;
        stop_btn  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        play_btn  = 1'b0;
        pause_btn = 1'b0;
        stop_btn  = 1'b0;
        loop_en   = 1'b0;
        tick_n(2);
        chk("rst_state", state, 2'b00);
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_code", bus.tone_code, 0);
        chk("rst_en", bus.tone_en, 0);
        chk("rst_tick", beat_tick, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        tick_n(1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pause_in_idle", state, 2'b00);

        // First song pass, no loop: E0 is the play edge.
        pulse(1'b1, 1'b0, 1'b0);
        chk("play_state", state, 2'b01);
        chk("play_en_rest", bus.tone_en, 0);
        tick_n(9);
        chk("e9_no_tick", beat_tick, 0);
        tick_n(1);
        chk("e10_tick", beat_tick, 1);
        chk("e10_addr", bus.rom_addr, 0);
        tick_n(1);
        chk("e11_tick_low", beat_tick, 0);
        chk("e11_addr", bus.rom_addr, 1);
        tick_n(2);
        chk("e13_code", bus.tone_code, 5);
        chk("e13_en", bus.tone_en, 1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("play_in_play", state, 2'b01);
        tick_n(6);
        chk("e20_tick", beat_tick, 1);
        tick_n(1);
        chk("e21_addr", bus.rom_addr, 2);
        tick_n(2);
        chk("e23_code", bus.tone_code, 7);
        tick_n(10);
        chk("e33_addr", bus.rom_addr, 3);
        chk("e33_code", bus.tone_code, 9);
        tick_n(7);
        chk("e40_tick", beat_tick, 1);
        chk("e40_no_done", done, 0);
        tick_n(1);
        chk("end_state", state, 2'b11);
        chk("end_done", done, 1);
        chk("end_addr", bus.rom_addr, 0);
        chk("end_en", bus.tone_en, 0);
        tick_n(1);
        chk("done_one_cycle", done, 0);
        chk("done_state_held", state, 2'b11);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pause_in_done", state, 2'b11);

        // Looping pass: F0 is the play edge out of DONE.
        loop_en = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        chk("restart_state", state, 2'b01);
        chk("restart_addr", bus.rom_addr, 0);
        tick_n(41);
        chk("loop_state", state, 2'b01);
        chk("loop_addr", bus.rom_addr, 0);
        chk("loop_no_done", done, 0);
        tick_n(2);
        chk("loop_rest_code", bus.tone_code, 0);
        chk("loop_rest_en", bus.tone_en, 0);
        tick_n(20);
        chk("f63_addr", bus.rom_addr, 2);
        chk("f63_code", bus.tone_code, 7);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pause_state", state, 2'b10);
        chk("pause_en", bus.tone_en, 0);
        for (int i = 0; i < 50; i++) begin
            tick_n(1);
            chk("pause_no_tick", beat_tick, 0);
        end
        chk("pause_addr_held", bus.rom_addr, 2);
        chk("pause_code_held", bus.tone_code, 7);
        chk("pause_en_held", bus.tone_en, 0);

        // Resume R: four counts were used before the pause, six remain.
        pulse(1'b1, 1'b0, 1'b0);
        chk("resume_state", state, 2'b01);
        chk("resume_en", bus.tone_en, 1);
        tick_n(5);
        chk("r5_no_tick", beat_tick, 0);
        tick_n(1);
        chk("r6_tick", beat_tick, 1);
        tick_n(1);
        chk("r7_addr", bus.rom_addr, 3);
        tick_n(29);
        chk("r36_tick", beat_tick, 1);
        chk("r36_addr", bus.rom_addr, 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("stop_state", state, 2'b00);
        chk("stop_addr", bus.rom_addr, 0);
        chk("stop_no_done", done, 0);
        chk("stop_en", bus.tone_en, 0);
        chk("stop_tick", beat_tick, 0);
        pulse(1'b1, 1'b0, 1'b1);
        chk("stop_beats_play", state, 2'b00);

        // Asynchronous reset mid-beat at addr 2, then a clean restart.
        loop_en = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        tick_n(21);
        chk("g21_addr", bus.rom_addr, 2);
        tick_n(4);
        chk("g25_code", bus.tone_code, 7);
        rst = 1'b0;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_addr", bus.rom_addr, 0);
        chk("arst_code", bus.tone_code, 0);
        chk("arst_en", bus.tone_en, 0);
        chk("arst_tick", beat_tick, 0);
        chk("arst_done", done, 0);
        tick_n(1);
        rst = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        chk("h0_state", state, 2'b01);
        chk("h0_addr", bus.rom_addr, 0);
        tick_n(9);
        chk("h9_no_tick", beat_tick, 0);
        tick_n(1);
        chk("h10_tick", beat_tick, 1);
        tick_n(1);
        chk("h11_addr", bus.rom_addr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
